// File: rtl/psk_pkg.sv
// psk_pkg
// Shared definitions for the PSK transmit framer and related blocks.
// Contents:
//   state_t    - framer FSM states (IDLE, PRE, HDR, PAY, CRC)
//   CRC8_POLY  - CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   DAC_W      - width of the signed DAC sample words
//   PRE_LEN    - preamble length in bits (one BPSK symbol per bit)
//   HDR_LEN    - length header size in bits
package psk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_HDR,
        ST_PAY,
        ST_CRC
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam int         DAC_W     = 12;
    localparam int         PRE_LEN   = 32;
    localparam int         HDR_LEN   = 8;

endpackage

// File: rtl/crc8_update.sv
// crc8_update
// Combinational single-byte CRC-8 step: polynomial CRC8_POLY, MSB first,
// no reflection. Chaining it across bytes starting from 8'h00 gives the
// frame CRC; the receiver checker can reuse it unchanged.
// Ports:
//   crc_in   - running CRC before this byte
//   data_in  - byte to fold in
//   crc_out  - running CRC after this byte
module crc8_update
    import psk_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);

    logic [7:0] acc;

    // XOR the byte into the register, then run eight shift/reduce steps.
    always_comb begin
        acc = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            acc = acc[7] ? ((acc << 1) ^ CRC8_POLY) : (acc << 1);
        end
        crc_out = acc;
    end

endmodule

// File: rtl/psk_tx_framer.sv
// psk_tx_framer
// Baseband BPSK/QPSK transmitter. Builds a frame of preamble, length header,
// payload and CRC-8, maps the bits to symbols and holds each symbol for SPS
// samples. All outputs are registered; the first preamble sample appears one
// edge after start is accepted.
// Ports:
//   clk_16M384, rst_n_16M384  - sample clock, synchronous active-low reset
//   start, len, is_bpsk       - frame request; len and mode latched with start
//   din, din_vld, din_rdy     - payload byte stream (one-entry buffer)
//   busy, done, err           - frame status; done/err are one-cycle pulses
//   DAC_I, DAC_Q              - signed I/Q samples (+/-AMP or 0)
//   DAC_bits, DAC_vld         - bits of the current symbol, sample valid
module psk_tx_framer
    import psk_pkg::*;
#(
    parameter int unsigned SPS      = 512,
    parameter int unsigned AMP      = 1024,
    parameter logic [31:0] PREAMBLE = 32'hA5A5_F0F0
) (
    input  logic                    clk_16M384,
    input  logic                    rst_n_16M384,
    input  logic                    start,
    input  logic [7:0]              len,
    input  logic                    is_bpsk,
    input  logic [7:0]              din,
    input  logic                    din_vld,
    output logic                    din_rdy,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic signed [DAC_W-1:0] DAC_I,
    output logic signed [DAC_W-1:0] DAC_Q,
    output logic [1:0]              DAC_bits,
    output logic                    DAC_vld
);

    localparam int                      CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(SPS - 1);
    localparam logic signed [DAC_W-1:0] AMP_POS   = DAC_W'(AMP);
    localparam logic signed [DAC_W-1:0] AMP_NEG   = -AMP_POS;
    localparam logic [5:0]              PRE_BITS  = 6'(PRE_LEN);
    localparam logic [5:0]              HDR_BITS  = 6'(HDR_LEN);
    localparam logic [5:0]              BYTE_BITS = 6'd8;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic [31:0]             sreg_q, sreg_d;
    logic [5:0]              bits_left_q, bits_left_d;
    logic [7:0]              len_q, len_d;
    logic                    bpsk_q, bpsk_d;
    logic [7:0]              buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic [7:0]              acc_cnt_q, acc_cnt_d;
    logic [7:0]              pay_cnt_q, pay_cnt_d;
    logic [7:0]              crc_q, crc_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic signed [DAC_W-1:0] dac_i_q, dac_i_d;
    logic signed [DAC_W-1:0] dac_q_q, dac_q_d;
    logic [1:0]              dac_bits_q, dac_bits_d;
    logic                    dac_vld_q, dac_vld_d;

    logic                    accept;
    logic                    boundary;
    logic                    load_sym;
    logic                    sym_qpsk;
    logic                    go_idle;
    logic [31:0]             src;
    logic [5:0]              src_bits;
    logic [7:0]              crc_next;

    // CRC advances on each accepted payload byte, not when it is sent, so the
    // final value is ready well before the CRC field starts.
    crc8_update u_crc8_update (
        .crc_in  (crc_q),
        .data_in (din),
        .crc_out (crc_next)
    );

    assign busy    = (state_q != ST_IDLE);
    assign din_rdy = busy && !buf_full_q && (acc_cnt_q < len_q);
    assign accept  = din_vld && din_rdy;

    // Next-state logic. A "symbol load" takes the top one (BPSK) or two
    // (QPSK) bits of src, which is either the remainder of the current field
    // or a fresh MSB-aligned field when the previous one ran out.
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        sreg_d      = sreg_q;
        bits_left_d = bits_left_q;
        len_d       = len_q;
        bpsk_d      = bpsk_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        acc_cnt_d   = acc_cnt_q;
        pay_cnt_d   = pay_cnt_q;
        crc_d       = crc_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dac_i_d     = dac_i_q;
        dac_q_d     = dac_q_q;
        dac_bits_d  = dac_bits_q;
        dac_vld_d   = dac_vld_q;
        load_sym    = 1'b0;
        sym_qpsk    = 1'b0;
        go_idle     = 1'b0;
        src         = sreg_q;
        src_bits    = bits_left_q;

        if (accept) begin
            buf_d      = din;
            buf_full_d = 1'b1;
            acc_cnt_d  = acc_cnt_q + 8'd1;
            crc_d      = crc_next;
        end

        boundary = busy && (sym_cnt_q == CNT_LAST);
        if (busy) begin
            sym_cnt_d = boundary ? '0 : sym_cnt_q + CNT_W'(1);
        end

        if (state_q == ST_IDLE) begin
            if (start && (len != 8'd0)) begin
                state_d    = ST_PRE;
                len_d      = len;
                bpsk_d     = is_bpsk;
                buf_full_d = 1'b0;
                acc_cnt_d  = 8'd0;
                pay_cnt_d  = 8'd0;
                crc_d      = 8'd0;
                sym_cnt_d  = '0;
                load_sym   = 1'b1;
                src        = PREAMBLE;
                src_bits   = PRE_BITS;
            end
        end else if (boundary) begin
            if (bits_left_q != 6'd0) begin
                load_sym = 1'b1;
                sym_qpsk = ((state_q == ST_PAY) || (state_q == ST_CRC)) && !bpsk_q;
            end else begin
                case (state_q)
                    ST_PRE: begin
                        state_d  = ST_HDR;
                        load_sym = 1'b1;
                        src      = {len_q, 24'h0};
                        src_bits = HDR_BITS;
                    end
                    ST_HDR, ST_PAY: begin
                        if (pay_cnt_q == len_q) begin
                            state_d  = ST_CRC;
                            load_sym = 1'b1;
                            sym_qpsk = !bpsk_q;
                            src      = {crc_q, 24'h0};
                            src_bits = BYTE_BITS;
                        end else if (buf_full_q) begin
                            state_d    = ST_PAY;
                            load_sym   = 1'b1;
                            sym_qpsk   = !bpsk_q;
                            src        = {buf_q, 24'h0};
                            src_bits   = BYTE_BITS;
                            buf_full_d = 1'b0;
                            pay_cnt_d  = pay_cnt_q + 8'd1;
                        end else begin
                            // Payload byte due but not delivered: abort.
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                            go_idle = 1'b1;
                        end
                    end
                    ST_CRC: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        go_idle = 1'b1;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        go_idle = 1'b1;
                    end
                endcase
            end
        end

        if (load_sym) begin
            dac_vld_d = 1'b1;
            dac_i_d   = src[31] ? AMP_NEG : AMP_POS;
            if (sym_qpsk) begin
                dac_q_d     = src[30] ? AMP_NEG : AMP_POS;
                dac_bits_d  = src[31:30];
                sreg_d      = {src[29:0], 2'b00};
                bits_left_d = src_bits - 6'd2;
            end else begin
                dac_q_d     = '0;
                dac_bits_d  = {1'b0, src[31]};
                sreg_d      = {src[30:0], 1'b0};
                bits_left_d = src_bits - 6'd1;
            end
        end else if (go_idle) begin
            dac_vld_d  = 1'b0;
            dac_i_d    = '0;
            dac_q_d    = '0;
            dac_bits_d = 2'b00;
            sym_cnt_d  = '0;
        end
    end

    // State and output registers; reset clears everything, which also
    // silently abandons any frame in flight.
    always_ff @(posedge clk_16M384) begin
        if (!rst_n_16M384) begin
            state_q     <= ST_IDLE;
            sym_cnt_q   <= '0;
            sreg_q      <= '0;
            bits_left_q <= '0;
            len_q       <= '0;
            bpsk_q      <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            acc_cnt_q   <= '0;
            pay_cnt_q   <= '0;
            crc_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            dac_i_q     <= '0;
            dac_q_q     <= '0;
            dac_bits_q  <= 2'b00;
            dac_vld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            sreg_q      <= sreg_d;
            bits_left_q <= bits_left_d;
            len_q       <= len_d;
            bpsk_q      <= bpsk_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            acc_cnt_q   <= acc_cnt_d;
            pay_cnt_q   <= pay_cnt_d;
            crc_q       <= crc_d;
            done_q      <= done_d;
            err_q       <= err_d;
            dac_i_q     <= dac_i_d;
            dac_q_q     <= dac_q_d;
            dac_bits_q  <= dac_bits_d;
            dac_vld_q   <= dac_vld_d;
        end
    end

    assign done     = done_q;
    assign err      = err_q;
    assign DAC_I    = dac_i_q;
    assign DAC_Q    = dac_q_q;
    assign DAC_bits = dac_bits_q;
    assign DAC_vld  = dac_vld_q;

endmodule

// File: doc/psk_tx_framer.md
Name: psk_tx_framer

Overview:
Baseband PSK transmitter that is the transmit-side counterpart of the BPSK/QPSK demodulator chain.
- Accepts payload bytes over a valid/ready stream and builds a frame: preamble, length header, payload, CRC-8.
- Maps the frame bits to BPSK or QPSK symbols and holds each symbol for SPS samples (rectangular pulse).
- Drives DAC_I/DAC_Q/DAC_bits/DAC_vld at the 16.384 MHz sample rate, ahead of the DAC or the loopback into the receiver.

Parameters:
SPS, 512, samples per symbol (>=2)
AMP, 1024, symbol amplitude magnitude (12-bit signed, <=2047)
PREAMBLE, 32'hA5A5_F0F0, preamble bit pattern, sent MSB first

Ports:
clk_16M384  in  1  sample clock
rst_n_16M384  in  1  synchronous reset, active low
start  in  1  frame request pulse
len  in  8  payload byte count, sampled with start; 0 is invalid
is_bpsk  in  1  payload modulation, sampled with start (1=BPSK, 0=QPSK)
din  in  8  payload byte
din_vld  in  1  din valid
din_rdy  out  1  block accepts din this cycle
busy  out  1  frame in progress
done  out  1  one-cycle pulse, frame completed
err  out  1  one-cycle pulse, frame aborted on underrun
DAC_I  out  12  signed I sample
DAC_Q  out  12  signed Q sample
DAC_bits  out  2  bits carried by the current symbol
DAC_vld  out  1  sample valid

Behaviour:
- Reset is synchronous and active low (rst_n_16M384 == 0 at a clk_16M384 rising edge).
  - All outputs go to 0 and the FSM goes to IDLE; the buffer, counters and CRC clear.
  - Reset asserted mid-frame aborts the frame silently: no done, no err.
- FSM states: IDLE -> PRE (32 symbols) -> HDR (8 bits) -> PAY (8*len bits) -> CRC (8 bits) -> IDLE.
- IDLE:
  - start=1 with len!=0 latches len and is_bpsk and enters PRE.
  - The first preamble sample appears at the next edge (latency 1 cycle).
  - start is ignored when len=0, and ignored whenever busy=1.
- Bit order is MSB first. HDR carries len. PRE and HDR are always BPSK; PAY and CRC use the latched mode.
- BPSK mapping:
  - bit 0 -> I=+AMP, bit 1 -> I=-AMP, Q=0.
  - DAC_bits={1'b0,b}.
- QPSK mapping:
  - Bits taken in pairs (b0,b1): b0 -> I, b1 -> Q, 0 -> +AMP, 1 -> -AMP.
  - DAC_bits={b0,b1}.
- Symbol timer:
  - Counter runs 0..SPS-1; the next symbol loads when the counter wraps.
  - Each symbol occupies exactly SPS consecutive cycles; there are no gaps between states.
- DAC_vld=1 on every cycle of PRE through CRC, and 0 in IDLE. While DAC_vld=0: DAC_I=DAC_Q=0, DAC_bits=0.
- Input buffer:
  - One-entry byte buffer.
  - din_rdy=1 when busy, the buffer is empty, and fewer than len bytes have been accepted.
  - Transfer occurs when din_vld & din_rdy.
  - Bytes are requested from PRE onward, so the first byte may be fetched during the preamble.
- Underrun:
  - Condition: a payload byte is needed at a symbol boundary and the buffer is empty.
  - Response: abort at that edge; DAC outputs go to 0, DAC_vld=0, err=1 for one cycle, FSM goes to IDLE.
- CRC-8:
  - Polynomial 0x07, init 0x00, no reflection, no final XOR.
  - Computed over payload bytes only; updated when each byte is accepted.
- done: 1 for one cycle, in the first IDLE cycle after the last CRC sample. It coincides with DAC_vld falling.
- Frame length in cycles: SPS*(40 + (8*len+8)/k), where k=1 for BPSK and k=2 for QPSK.
- Simultaneous events:
  - Reset overrides everything.
  - A start in the done cycle is accepted; the new frame starts on the next edge.

Decomposition:
- Package psk_pkg holds:
  - FSM state enum;
  - CRC8_POLY=8'h07;
  - DAC width constant (12);
  - preamble length constant (32);
  - header length constant (8).
- Sub-module crc8_update: combinational, 8-bit crc in + data byte in -> 8-bit crc out. Reusable by the receiver checker.

Test Plan:
1. SPS=4, BPSK, len=1, din=8'h00 presented from start -> first 4 samples I=-1024, Q=0, DAC_bits=2'b01; 224 DAC_vld cycles; CRC field 0x00; done at cycle 225.
2. SPS=4, QPSK, len=2, din=8'h1B, 8'hE4 -> payload symbols (I,Q) = (+,+),(+,-),(-,+),(-,-),(-,-),(-,+),(+,-),(+,+) at ±1024; 208 DAC_vld cycles; CRC matches the golden model.
3. CRC check, BPSK, len=1: din=8'h01 -> CRC bits 0x07; din=8'hFF -> CRC bits 0xF3.
4. Underrun: len=3, only 1 byte supplied -> err pulse at the 2nd payload-byte boundary; next cycle DAC_vld=0, DAC_I=DAC_Q=0, busy=0, done never asserts.
5. Ignored requests:
   - start with len=0 -> busy stays 0.
   - start mid-frame -> the frame completes unchanged with its original len and mode.
6. rst_n_16M384=0 for one cycle mid-payload -> next cycle all outputs 0 and no done/err; a new start afterwards produces a correct frame.
